fpu_addsub_pipe: RTL and testbench

- Parametrised, multi-cycle floating-point add/subtract unit for the custom sign/exponent/mantissa format.
- Generalises the fixed 1/10/21-bit adder in three ways: parametrised field widths, an explicit add/subtract mode, and valid/ready handshakes on input and output.
- Adds guard/round/sticky tracking with round-to-nearest-even, zero-operand handling, and saturating overflow and underflow.
- Sits between the operand register file and result writeback; one operation is in flight at a time.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_round_rne.sv | 22 ++
 rtl/fpu_addsub_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fpu_addsub_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the sign/exponent/mantissa add/subtract datapath.
package fpu_pkg;

    typedef enum logic [1:0] {
        EXACT     = 2'd0,
        INEXACT   = 2'd1,
        OVERFLOW  = 2'd2,
        UNDERFLOW = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ALIGN,
        S_OPERATE,
        S_NORMALIZE,
        S_ROUND,
        S_OUTPUT
    } fsm_t;

    localparam int DEF_EXP_W  = 10;
    localparam int DEF_MANT_W = 21;

    // Field view of a word at the default widths; modules with other widths declare their own.
    typedef struct packed {
        logic                  sign;
        logic [DEF_EXP_W-1:0]  expo;
        logic [DEF_MANT_W-1:0] mant;
    } fp_default_t;

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even of a normalised significand (hidden bit included) using guard/round/sticky.
module fpu_round_rne #(
    parameter int MANT_W = 21
) (
    input  logic [MANT_W:0]   mant_i,
    input  logic              guard_i,
    input  logic              round_i,
    input  logic              sticky_i,
    output logic [MANT_W-1:0] mant_o,
    output logic              carry_o,
    output logic              inexact_o
);

    logic round_up;

    assign round_up  = guard_i & (round_i | sticky_i | mant_i[0]);
    // Only an all-ones significand can carry out; the fraction then wraps to zero.
    assign carry_o   = round_up & (&mant_i);
    assign mant_o    = mant_i[MANT_W-1:0] + MANT_W'(round_up);
    assign inexact_o = guard_i | round_i | sticky_i;

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Multi-cycle floating-point add/subtract with valid/ready handshakes and RNE rounding.
module fpu_addsub_pipe
    import fpu_pkg::*;
#(
    parameter  int EXP_W  = 10,
    parameter  int MANT_W = 21,
    parameter  int BIAS   = 2**(EXP_W-1)-1,
    localparam int W      = 1 + EXP_W + MANT_W
) (
    input  logic         clock_100Khz,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output status_t      status_out
);

    // Working significand layout: {carry, hidden, fraction, guard, round, sticky}.
    localparam int XW = MANT_W + 5;
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expo;
        logic [MANT_W-1:0] mant;
    } fp_t;

    // The bias only changes how the exponent is read, never the datapath.
    if (BIAS < 0) begin : g_bias_unused
    end

    fsm_t           state_q;
    fp_t            a_q, b_q;
    logic           sub_q;
    logic           sign_q, eff_add_q;
    logic [EXP_W:0] exp_q;
    logic [EXP_W-1:0] diff_q;
    logic [XW-1:0]  wk_q, small_q;
    logic           in_ready_q, out_valid_q;
    logic [W-1:0]   data_q;
    status_t        status_q;

    fp_t            b_eff, big_op, small_op;
    logic           a_ge_b;
    logic [XW-1:0]  op_res;
    logic [MANT_W-1:0] rnd_mant;
    logic           rnd_carry, rnd_inexact;
    logic [EXP_W:0] rnd_exp;

    always_comb begin
        b_eff      = b_q;
        b_eff.sign = b_q.sign ^ sub_q;
        a_ge_b     = {a_q.expo, a_q.mant} >= {b_q.expo, b_q.mant};
        big_op     = a_ge_b ? a_q : b_eff;
        small_op   = a_ge_b ? b_eff : a_q;
        op_res     = eff_add_q ? (wk_q + small_q) : (wk_q - small_q);
        rnd_exp    = exp_q + {{EXP_W{1'b0}}, rnd_carry};
    end

    fpu_round_rne #(.MANT_W(MANT_W)) u_round (
        .mant_i    (wk_q[XW-2:3]),
        .guard_i   (wk_q[2]),
        .round_i   (wk_q[1]),
        .sticky_i  (wk_q[0]),
        .mant_o    (rnd_mant),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inexact)
    );

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            sign_q      <= 1'b0;
            eff_add_q   <= 1'b0;
            exp_q       <= '0;
            diff_q      <= '0;
            wk_q        <= '0;
            small_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            status_q    <= EXACT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= op_a;
                        b_q        <= op_b;
                        sub_q      <= op_sub;
                        in_ready_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (a_q.expo == '0 || b_q.expo == '0) begin
                        if (a_q.expo == '0 && b_q.expo == '0) data_q <= '0;
                        else if (a_q.expo == '0)              data_q <= b_eff;
                        else                                  data_q <= a_q;
                        status_q    <= EXACT;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUTPUT;
                    end else begin
                        sign_q    <= big_op.sign;
                        eff_add_q <= (a_q.sign == b_eff.sign);
                        exp_q     <= {1'b0, big_op.expo};
                        diff_q    <= big_op.expo - small_op.expo;
                        wk_q      <= {2'b01, big_op.mant, 3'b000};
                        small_q   <= {2'b01, small_op.mant, 3'b000};
                        state_q   <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (32'(diff_q) > MANT_W + 3) begin
                        small_q <= {{(XW-1){1'b0}}, |small_q};
                        state_q <= S_OPERATE;
                    end else if (diff_q == '0) begin
                        state_q <= S_OPERATE;
                    end else begin
                        small_q <= {1'b0, small_q[XW-1:2], |small_q[1:0]};
                        diff_q  <= diff_q - 1'b1;
                        if (diff_q == EXP_W'(1)) state_q <= S_OPERATE;
                    end
                end
                S_OPERATE: begin
                    if (op_res == '0) begin
                        data_q      <= '0;
                        status_q    <= EXACT;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUTPUT;
                    end else begin
                        wk_q    <= op_res;
                        state_q <= S_NORMALIZE;
                    end
                end
                S_NORMALIZE: begin
                    if (wk_q[XW-1]) begin
                        wk_q    <= {1'b0, wk_q[XW-1:2], |wk_q[1:0]};
                        exp_q   <= exp_q + 1'b1;
                        state_q <= S_ROUND;
                    end else if (wk_q[XW-2]) begin
                        state_q <= S_ROUND;
                    end else if (exp_q < (EXP_W+1)'(2)) begin
                        data_q      <= {sign_q, {(W-1){1'b0}}};
                        status_q    <= UNDERFLOW;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUTPUT;
                    end else begin
                        wk_q  <= {wk_q[XW-2:0], 1'b0};
                        exp_q <= exp_q - 1'b1;
                    end
                end
                S_ROUND: begin
                    if (rnd_exp >= EXP_MAX) begin
                        data_q   <= {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                        status_q <= OVERFLOW;
                    end else begin
                        data_q   <= {sign_q, rnd_exp[EXP_W-1:0], rnd_mant};
                        status_q <= rnd_inexact ? INEXACT : EXACT;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign data_out   = data_q;
    assign status_out = status_q;

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Self-checking bench for fpu_addsub_pipe: directed cases, randomized ops against an exact-arithmetic model.
module tb_fpu_addsub_pipe;
    import fpu_pkg::*;

    logic        clock_100Khz;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a, op_b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    status_t     status_out;

    int checks = 0;
    int errors = 0;

    fpu_addsub_pipe #(.EXP_W(10), .MANT_W(21)) dut (
        .clock_100Khz (clock_100Khz),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_sub       (op_sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .status_out   (status_out)
    );

    initial clock_100Khz = 1'b0;
    always #5 clock_100Khz = ~clock_100Khz;

    // Exact reference: scale both significands by 2^K, jam lost bits into the LSB, then round RNE.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  output logic [31:0] res, output logic [1:0] st);
        int K = 48;
        logic sa, sb, sbig, ssml;
        int ea, eb, ebig, esml, diff, p, e, sh;
        logic [20:0] fbig, fsml;
        logic [95:0] x, s0, s, r, sig, rem, half;
        sa = a[31]; ea = int'(a[30:21]);
        sb = b[31] ^ sub; eb = int'(b[30:21]);
        if (ea == 0 && eb == 0) begin res = '0; st = 2'd0; return; end
        if (ea == 0) begin res = {sb, b[30:0]}; st = 2'd0; return; end
        if (eb == 0) begin res = a; st = 2'd0; return; end
        if (a[30:0] >= b[30:0]) begin
            sbig = sa; ebig = ea; fbig = a[20:0]; ssml = sb; esml = eb; fsml = b[20:0];
        end else begin
            sbig = sb; ebig = eb; fbig = b[20:0]; ssml = sa; esml = ea; fsml = a[20:0];
        end
        diff = ebig - esml;
        x  = {74'd0, 1'b1, fbig} << K;
        s0 = {74'd0, 1'b1, fsml} << K;
        s  = s0 >> diff;
        if ((s << diff) != s0) s[0] = 1'b1;
        r = (sbig == ssml) ? x + s : x - s;
        if (r == '0) begin res = '0; st = 2'd0; return; end
        p = 95;
        while (!r[p]) p--;
        e = ebig + p - (K + 21);
        if (e <= 0) begin res = {sbig, 31'd0}; st = 2'd3; return; end
        sh   = p - 21;
        sig  = r >> sh;
        rem  = r - (sig << sh);
        half = 96'd1 << (sh - 1);
        if (rem > half || (rem == half && sig[0])) sig = sig + 96'd1;
        if (sig == (96'd1 << 22)) begin sig = sig >> 1; e++; end
        if (e >= 1023) begin
            res = {sbig, 10'h3FF, 21'd0}; st = 2'd2;
        end else begin
            res = {sbig, 10'(e), sig[20:0]}; st = (rem != '0) ? 2'd1 : 2'd0;
        end
    endfunction

    // Drives one full transaction; called at posedge+1. lat counts the accept edge as 1.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] res, output logic [1:0] st, output int lat, output bit tmo);
        int w = 0;
        while (!in_ready && w < 100) begin @(posedge clock_100Khz); #1; w++; end
        op_a = a; op_b = b; op_sub = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clock_100Khz); #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_sub = ~s;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clock_100Khz); #1; lat++; end
        tmo = !out_valid;
        res = data_out;
        st  = status_out;
        out_ready = 1'b1;
        @(posedge clock_100Khz); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_sub = 1'b0;
        repeat (2) @(posedge clock_100Khz);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h expected 00000000", data_out); end
        checks++; if (status_out !== EXACT) begin errors++; $display("FAIL reset_status got %0d expected 0", status_out); end
        @(negedge clock_100Khz) reset = 1'b1;
        @(posedge clock_100Khz); #1;
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        s;
        logic [31:0] res;
        logic [1:0]  st;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        logic [31:0] res; logic [1:0] st; int lat; bit tmo;
        v.push_back('{32'h3FE00000, 32'h3FE00000, 1'b0, 32'h40000000, 2'd0, 6});
        v.push_back('{32'h40100000, 32'h3FE00000, 1'b1, 32'h40000000, 2'd0, 0});
        v.push_back('{32'h3FE00000, 32'h3FE00000, 1'b1, 32'h00000000, 2'd0, 4});
        v.push_back('{32'h3FE00000, 32'h3D200000, 1'b0, 32'h3FE00000, 2'd1, 0});
        v.push_back('{32'h3FE00001, 32'h3D200000, 1'b0, 32'h3FE00002, 2'd1, 0});
        v.push_back('{32'h7FDFFFFF, 32'h7FDFFFFF, 1'b0, 32'h7FE00000, 2'd2, 0});
        v.push_back('{32'h00300000, 32'h00200000, 1'b1, 32'h00000000, 2'd3, 0});
        v.push_back('{32'h00000000, 32'h3FE00000, 1'b1, 32'hBFE00000, 2'd0, 2});
        v.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 2'd0, 2});
        foreach (v[i]) begin
            do_op(v[i].a, v[i].b, v[i].s, res, st, lat, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL dir%0d_timeout got no out_valid expected out_valid", i); end
            checks++; if (res !== v[i].res) begin errors++; $display("FAIL dir%0d_data got %h expected %h", i, res, v[i].res); end
            checks++; if (st !== v[i].st) begin errors++; $display("FAIL dir%0d_status got %0d expected %0d", i, st, v[i].st); end
            if (v[i].lat != 0) begin
                checks++; if (lat != v[i].lat) begin errors++; $display("FAIL dir%0d_latency got %0d expected %0d", i, lat, v[i].lat); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp_res; logic [1:0] st, exp_st; logic s; int lat; bit tmo;
        int ea, eb, mode;
        for (int n = 0; n < 250; n++) begin
            mode = $urandom_range(0, 9);
            case (mode)
                0:       ea = 0;
                1:       ea = $urandom_range(1, 4);
                2:       ea = $urandom_range(1018, 1023);
                default: ea = $urandom_range(1, 1023);
            endcase
            eb = ea + $urandom_range(0, 60) - 30;
            if (eb < 1) eb = 1;
            if (eb > 1023) eb = 1023;
            if ($urandom_range(0, 19) == 0) eb = 0;
            if (mode == 9) eb = $urandom_range(1, 1023);
            a = {1'($urandom), 10'(ea), 21'($urandom)};
            b = {1'($urandom), 10'(eb), 21'($urandom)};
            if (mode == 3) b = {b[31], a[30:0] ^ 31'($urandom_range(0, 7))};
            s = 1'($urandom);
            model(a, b, s, exp_res, exp_st);
            do_op(a, b, s, res, st, lat, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL rnd%0d_timeout a=%h b=%h sub=%b", n, a, b, s); end
            checks++; if (res !== exp_res) begin errors++; $display("FAIL rnd%0d_data a=%h b=%h sub=%b got %h expected %h", n, a, b, s, res, exp_res); end
            checks++; if (st !== exp_st) begin errors++; $display("FAIL rnd%0d_status a=%h b=%h sub=%b got %0d expected %0d", n, a, b, s, st, exp_st); end
            checks++; if (lat > 52) begin errors++; $display("FAIL rnd%0d_latency got %0d expected <= 52", n, lat); end
        end
    endtask

    task automatic test_backpressure();
        int w = 0;
        op_a = 32'h3FE00000; op_b = 32'h3FE00000; op_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clock_100Khz); #1;
        op_a = 32'h40100000; op_sub = 1'b1;
        while (!out_valid && w < 100) begin @(posedge clock_100Khz); #1; w++; end
        checks++; if (!out_valid) begin errors++; $display("FAIL bp_timeout got no out_valid expected out_valid"); end
        for (int c = 0; c < 10; c++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d got %b expected 1", c, out_valid); end
            checks++; if (data_out !== 32'h40000000) begin errors++; $display("FAIL bp_data cyc%0d got %h expected 40000000", c, data_out); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %b expected 0", c, in_ready); end
            @(posedge clock_100Khz); #1;
        end
        out_ready = 1'b1;
        @(posedge clock_100Khz); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept_on_handshake got in_ready %b expected 1", in_ready); end
    endtask

    task automatic test_reset_mid_align();
        logic [31:0] res; logic [1:0] st; int lat; bit tmo;
        op_a = 32'h3FE00000; op_b = 32'h3D200000; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clock_100Khz); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock_100Khz);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b expected 0", out_valid); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL midrst_data got %h expected 00000000", data_out); end
        checks++; if (status_out !== EXACT) begin errors++; $display("FAIL midrst_status got %0d expected 0", status_out); end
        @(negedge clock_100Khz) reset = 1'b1;
        repeat (40) @(posedge clock_100Khz);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard got out_valid %b expected 0", out_valid); end
        do_op(32'h40100000, 32'h3FE00000, 1'b0, res, st, lat, tmo);
        checks++; if (res !== 32'h40200000) begin errors++; $display("FAIL midrst_after_data got %h expected 40200000", res); end
        checks++; if (st !== 2'd0) begin errors++; $display("FAIL midrst_after_status got %0d expected 0", st); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
